wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port (and the execute bypass) between NREQ result producers.
//  Producers are the in-order pipeline (requester 0), the load/store completion path and the mul/div unit.
//  Uses fixed priority for requester 0 and round-robin among requesters 1..NREQ-1.
//  Anti-starvation counter; one registered write stage, so port outputs are flop-driven.
// PARAMETERS
//  XLEN         `XLEN  datapath width, from macros.hv
//  NREQ         3      number of requesters; must be >= 2; requester 0 is the pipeline
//  STARVE_LIMIT 8      consecutive lost cycles before requesters 1..NREQ-1 pre-empt req 0; 0 disables
// PORTS
//  clk                 in   1          clock
//  rst                 in   1          reset; one clock, synchronous, active-high
//  i_req_valid         in   NREQ       request valid, one bit per requester
//  o_req_ready         out  NREQ       request accepted this cycle (combinational)
//  i_req_rd            in   NREQ*5     destination register, requester k at [5k+4:5k]
//  i_req_data          in   NREQ*XLEN  result, requester k at [XLEN*k+XLEN-1:XLEN*k]
//  o_reg_write_en      out  1          register-file write enable
//  o_reg_addr          out  5          register-file write address
//  o_reg_data          out  XLEN       register-file write data
//  o_exec_bypass_reg   out  5          bypass register id; 0 = no bypass
//  o_exec_bypass_data  out  XLEN       bypass data
//  o_wb_src            out  clog2(NREQ)  requester that produced the current write
// BEHAVIOUR
//  Handshake
//   - Transfer on valid&&ready in the same cycle.
//   - Requester holds valid/rd/data stable until ready; ready never depends on a prior ready.
//  Eligibility and zero-register requests
//   - Eligible = valid && rd!=0.
//   - valid with rd==0: ready=1 the same cycle, no write.
//   - Zero-register requests do not take the grant, move rr_ptr or affect the counter.
//  Grant: at most one eligible requester per cycle
//   - starve && any eligible k>=1 -> round-robin winner.
//   - else req 0 eligible -> 0.
//   - else any eligible k>=1 -> round-robin winner.
//   - else none.
//  Round-robin
//   - rr_ptr is in 1..NREQ-1; search from rr_ptr upward, wrapping NREQ-1 -> 1.
//   - On grant to k>=1: rr_ptr <= k+1, wrapping to 1. Unchanged otherwise.
//  Starvation counter
//   - Increments (saturating at STARVE_LIMIT) when some k>=1 is eligible and grant==0.
//   - Clears on a grant to k>=1 or when no k>=1 is eligible.
//   - starve = (cnt==STARVE_LIMIT) && STARVE_LIMIT!=0.
//  Output stage, latency 1
//   - Grant accepted in cycle N appears in N+1: write_en=1, addr=rd, data, src=k.
//   - No grant: write_en=0, addr=0, data=0, src=0.
//   - Bypass outputs mirror addr/data exactly.
//   - write_en is 1 only if addr!=0.
//  Reset
//   - While rst=1: all o_req_ready=0.
//   - Next edge: all outputs 0, rr_ptr=1, cnt=0.
//   - Reset mid-transfer drops the in-flight write: write_en=0 on the cycle after the rst edge.
//  Same rd from two requesters: serialized in grant order; the later write wins. No merging.
// STRUCTURE
//  - macros.hv: `XLEN; localparam REQ_PIPE=0.
//  - Sub-module rr_picker: mask + priority pick over NREQ-1 requests from rr_ptr, combinational.
//  - Top module holds rr_ptr, the starvation counter and the output register.
// TESTING (NREQ=3, STARVE_LIMIT=4 unless noted)
//  1 Reset: rst=1 for 2 cycles, all valid -> ready=000 throughout; after release write_en=0, addr=0, data=0.
//  2 Single: req0 rd=5 data=0xDEADBEEF -> ready0=1 at N; at N+1 write_en=1, addr=5, data=0xDEADBEEF, bypass_reg=5, src=0.
//  3 Starvation: all three valid, distinct rd!=0 held forever -> grant sequence 0,0,0,0,1,0,0,0,0,2,0,0,0,0,1.
//  4 Zero rd: req0 rd=3 and req1 rd=0 same cycle -> ready=011; one write to x3 only; rr_ptr and cnt unchanged.
//  5 Round-robin: req1 and req2 valid, req0 idle -> grants 1,2,1,2; cnt stays 0.
//  6 Reset mid-op: grant req2 at N, rst=1 at N+1 -> write_en=0 at N+2; after release req1 and req2 valid -> req1 granted first.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg
//   Shared definitions for the write-back port arbiter: default datapath
//   width, the index of the in-order pipeline requester, the grant-kind
//   enum and small helpers for index widths and round-robin pointer advance.
package wb_port_arbiter_pkg;

  localparam int DEF_XLEN = 32;
  localparam int REQ_PIPE = 0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_RR   = 2'd2
  } gnt_kind_e;

  // Width of a requester index; at least one bit even for NREQ == 2.
  function automatic int src_width(input int nreq);
    return (nreq > 2) ? $clog2(nreq) : 1;
  endfunction

  // Round-robin pointer after a grant to requester k (k >= 1); wraps to 1.
  function automatic int next_rr(input int k, input int nreq);
    return (k >= nreq - 1) ? 1 : k + 1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_picker.sv
// wb_port_arbiter_rr_picker
//   Combinational round-robin pick among requesters 1..NREQ-1.
//   Ports:
//     req   in   NREQ-1  eligibility of requesters 1..NREQ-1 (bit j = requester j+1)
//     ptr   in   SW      round-robin start point, in 1..NREQ-1
//     found out  1       some requester is eligible
//     idx   out  SW      winning requester number (1..NREQ-1), 0 if none
module wb_port_arbiter_rr_picker
  import wb_port_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  localparam int SW  = src_width(NREQ)
) (
  input  logic [NREQ-2:0] req,
  input  logic [SW-1:0]   ptr,
  output logic            found,
  output logic [SW-1:0]   idx
);

  logic          hi_found;
  logic [SW-1:0] hi_idx;
  logic [SW-1:0] lo_idx;

  // Scanning downward leaves the lowest match in each slot. The masked
  // (k >= ptr) pick has priority; the unmasked pick provides the wrap.
  always_comb begin
    found    = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = NREQ - 1; k >= 1; k--) begin
      if (req[k-1]) begin
        found  = 1'b1;
        lo_idx = SW'(k);
        if (SW'(k) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = SW'(k);
        end
      end
    end
    idx = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register-file write port and the execute bypass between NREQ
//   result producers. Requester 0 (in-order pipeline) has fixed priority;
//   requesters 1..NREQ-1 are served round-robin and pre-empt requester 0
//   after STARVE_LIMIT consecutive lost cycles. Writes are registered, so
//   all write/bypass outputs are flop-driven with one cycle of latency.
//   Ports:
//     clk, rst             clock; synchronous active-high reset
//     i_req_valid  [NREQ]  request valid per requester
//     o_req_ready  [NREQ]  request accepted this cycle (combinational)
//     i_req_rd     [5*NREQ]     destination register, requester k at [5k+:5]
//     i_req_data   [XLEN*NREQ]  result, requester k at [XLEN*k+:XLEN]
//     o_reg_write_en/addr/data  register-file write port
//     o_exec_bypass_reg/data    bypass (mirror of the write port; reg 0 = none)
//     o_wb_src                  requester that produced the current write
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN         = DEF_XLEN,
  parameter int NREQ         = 3,
  parameter int STARVE_LIMIT = 8,
  localparam int SW          = src_width(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*5-1:0]    i_req_rd,
  input  logic [NREQ*XLEN-1:0] i_req_data,
  output logic                 o_reg_write_en,
  output logic [4:0]           o_reg_addr,
  output logic [XLEN-1:0]      o_reg_data,
  output logic [4:0]           o_exec_bypass_reg,
  output logic [XLEN-1:0]      o_exec_bypass_data,
  output logic [SW-1:0]        o_wb_src
);

  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] zero_rd;
  logic [SW-1:0]   rr_ptr;
  logic [SW-1:0]   rr_idx;
  logic            rr_found;
  logic [CW-1:0]   cnt;
  logic            starve;
  gnt_kind_e       gnt_kind;
  logic            gnt_valid;
  logic [SW-1:0]   gnt_idx;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            wr_en_q;
  logic [4:0]      addr_q;
  logic [XLEN-1:0] data_q;
  logic [SW-1:0]   src_q;

  // Requests to x0 are acknowledged but never compete for the port.
  always_comb begin
    elig    = '0;
    zero_rd = '0;
    for (int k = 0; k < NREQ; k++) begin
      zero_rd[k] = (i_req_rd[5*k +: 5] == 5'd0);
      elig[k]    = i_req_valid[k] && !zero_rd[k];
    end
  end

  wb_port_arbiter_rr_picker #(
    .NREQ (NREQ)
  ) u_rr_picker (
    .req   (elig[NREQ-1:1]),
    .ptr   (rr_ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

  assign starve = (STARVE_LIMIT != 0) && (cnt == CW'(STARVE_LIMIT));

  always_comb begin
    gnt_kind = GNT_NONE;
    gnt_idx  = '0;
    if (starve && rr_found) begin
      gnt_kind = GNT_RR;
      gnt_idx  = rr_idx;
    end else if (elig[REQ_PIPE]) begin
      gnt_kind = GNT_PIPE;
      gnt_idx  = SW'(REQ_PIPE);
    end else if (rr_found) begin
      gnt_kind = GNT_RR;
      gnt_idx  = rr_idx;
    end
  end

  assign gnt_valid = (gnt_kind != GNT_NONE);

  always_comb begin
    o_req_ready = '0;
    sel_rd      = '0;
    sel_data    = '0;
    for (int k = 0; k < NREQ; k++) begin
      o_req_ready[k] = !rst && i_req_valid[k] &&
                       (zero_rd[k] || (gnt_valid && gnt_idx == SW'(k)));
      if (gnt_valid && gnt_idx == SW'(k)) begin
        sel_rd   = i_req_rd[5*k +: 5];
        sel_data = i_req_data[XLEN*k +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      src_q   <= '0;
      rr_ptr  <= SW'(1);
      cnt     <= '0;
    end else begin
      wr_en_q <= gnt_valid;
      addr_q  <= sel_rd;
      data_q  <= sel_data;
      src_q   <= gnt_idx;
      if (gnt_kind == GNT_RR) begin
        rr_ptr <= SW'(next_rr(int'(gnt_idx), NREQ));
        cnt    <= '0;
      end else if (rr_found) begin
        // Requester 0 won while someone else waited; saturate at the limit.
        if (cnt != CW'(STARVE_LIMIT)) cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  assign o_reg_write_en     = wr_en_q;
  assign o_reg_addr         = addr_q;
  assign o_reg_data         = data_q;
  assign o_exec_bypass_reg  = addr_q;
  assign o_exec_bypass_data = data_q;
  assign o_wb_src           = src_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 3;
  localparam int LIM  = 4;
  localparam int SW   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      valid;
  logic [NREQ-1:0]      ready;
  logic [NREQ*5-1:0]    rd_bus;
  logic [NREQ*XLEN-1:0] data_bus;
  logic                 we;
  logic [4:0]           addr;
  logic [XLEN-1:0]      wdata;
  logic [4:0]           byp_reg;
  logic [XLEN-1:0]      byp_data;
  logic [SW-1:0]        src;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .XLEN         (XLEN),
    .NREQ         (NREQ),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_req_valid        (valid),
    .o_req_ready        (ready),
    .i_req_rd           (rd_bus),
    .i_req_data         (data_bus),
    .o_reg_write_en     (we),
    .o_reg_addr         (addr),
    .o_reg_data         (wdata),
    .o_exec_bypass_reg  (byp_reg),
    .o_exec_bypass_data (byp_data),
    .o_wb_src           (src)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state kept as plain integers.
  bit              m_live = 1'b0;
  int              m_ptr;
  int              m_cnt;
  logic            m_we;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  int              m_src;
  logic [NREQ-1:0] last_ready = '0;

  function automatic int rd_of(input int k);
    return int'(rd_bus[5*k +: 5]);
  endfunction

  function automatic bit elig(input int k);
    return valid[k] && rd_of(k) != 0;
  endfunction

  function automatic int rr_choice();
    for (int off = 0; off < NREQ - 1; off++) begin
      int k;
      k = ((m_ptr - 1 + off) % (NREQ - 1)) + 1;
      if (elig(k)) return k;
    end
    return -1;
  endfunction

  function automatic int winner();
    int rr;
    rr = rr_choice();
    if (rr >= 0 && LIM != 0 && m_cnt == LIM) return rr;
    if (elig(0)) return 0;
    return rr;
  endfunction

  always @(posedge clk) begin : model
    int w;
    int rr;
    if (rst) begin
      m_live = 1'b1;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_src  = 0;
      m_ptr  = 1;
      m_cnt  = 0;
    end else if (m_live) begin
      w  = winner();
      rr = rr_choice();
      if (w >= 0) begin
        m_we   = 1'b1;
        m_addr = rd_bus[5*w +: 5];
        m_data = data_bus[XLEN*w +: XLEN];
        m_src  = w;
      end else begin
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_src  = 0;
      end
      if (w >= 1) begin
        m_ptr = (w == NREQ - 1) ? 1 : w + 1;
        m_cnt = 0;
      end else if (rr >= 1) begin
        m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
      end else begin
        m_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] er;
    int w;
    if (m_live) begin
      w = rst ? -1 : winner();
      for (int k = 0; k < NREQ; k++)
        er[k] = !rst && valid[k] && (rd_of(k) == 0 || k == w);
      chk("ready", 64'(ready), 64'(er));
      chk("write_en", 64'(we), 64'(m_we));
      chk("addr", 64'(addr), 64'(m_addr));
      chk("data", 64'(wdata), 64'(m_data));
      chk("bypass_reg", 64'(byp_reg), 64'(m_addr));
      chk("bypass_data", 64'(byp_data), 64'(m_data));
      chk("src", 64'(src), 64'(m_src));
    end
    last_ready = ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit v, input logic [4:0] r, input logic [XLEN-1:0] d);
    valid[k]                 = v;
    rd_bus[5*k +: 5]         = r;
    data_bus[XLEN*k +: XLEN] = d;
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b0, 5'd0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    tick();
    rst = 1'b0;
  endtask

  int exp_starve[15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1};
  int exp_rr[4]      = '{1, 2, 1, 2};
  int exp_after[5]   = '{0, 0, 0, 0, 1};

  initial begin
    int pv;
    rst = 1'b1;
    clear_reqs();
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 5'(k + 1), 32'h100 + 32'(k));

    // Reset held two cycles with every requester valid.
    @(negedge clk);
    chk("rst_ready_a", 64'(ready), 64'd0);
    tick();
    @(negedge clk);
    chk("rst_ready_b", 64'(ready), 64'd0);
    tick();
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_data", 64'(wdata), 64'd0);

    // Single pipeline write.
    rst = 1'b0;
    clear_reqs();
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_ready", 64'(ready), 64'b001);
    tick();
    chk("single_we", 64'(we), 64'd1);
    chk("single_addr", 64'(addr), 64'd5);
    chk("single_data", 64'(wdata), 64'hDEADBEEF);
    chk("single_byp", 64'(byp_reg), 64'd5);
    chk("single_src", 64'(src), 64'd0);
    clear_reqs();

    // Starvation: all three held valid.
    do_reset();
    set_req(0, 1'b1, 5'd10, 32'hA0);
    set_req(1, 1'b1, 5'd11, 32'hA1);
    set_req(2, 1'b1, 5'd12, 32'hA2);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("starve_we", 64'(we), 64'd1);
      chk("starve_seq", 64'(src), 64'(exp_starve[i]));
    end

    // Zero-register request alongside a real one.
    do_reset();
    set_req(0, 1'b1, 5'd3, 32'h33);
    set_req(1, 1'b1, 5'd0, 32'h44);
    @(negedge clk);
    chk("zr_ready", 64'(ready), 64'b011);
    tick();
    chk("zr_we", 64'(we), 64'd1);
    chk("zr_addr", 64'(addr), 64'd3);
    chk("zr_src", 64'(src), 64'd0);
    clear_reqs();
    set_req(1, 1'b1, 5'd7, 32'h77);
    set_req(2, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    chk("zr_ptr_ready", 64'(ready), 64'b010);
    tick();
    chk("zr_ptr_src", 64'(src), 64'd1);
    clear_reqs();
    tick();
    chk("zr_idle_we", 64'(we), 64'd0);

    // Round-robin between requesters 1 and 2, then confirm the counter stayed 0.
    do_reset();
    set_req(1, 1'b1, 5'd20, 32'hB1);
    set_req(2, 1'b1, 5'd21, 32'hB2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_seq", 64'(src), 64'(exp_rr[i]));
    end
    set_req(0, 1'b1, 5'd22, 32'hB0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_cnt_seq", 64'(src), 64'(exp_after[i]));
    end

    // Reset in the middle of a write.
    do_reset();
    set_req(2, 1'b1, 5'd4, 32'hC2);
    tick();
    chk("mid_we", 64'(we), 64'd1);
    chk("mid_src", 64'(src), 64'd2);
    rst = 1'b1;
    clear_reqs();
    tick();
    chk("mid_drop_we", 64'(we), 64'd0);
    rst = 1'b0;
    set_req(1, 1'b1, 5'd6, 32'hD1);
    set_req(2, 1'b1, 5'd8, 32'hD2);
    @(negedge clk);
    chk("mid_ready", 64'(ready), 64'b010);
    tick();
    chk("mid_first_src", 64'(src), 64'd1);
    clear_reqs();
    tick();

    // Random traffic with held requests, colliding rd values and sporadic reset.
    for (int blk = 0; blk < 6; blk++) begin
      pv = (blk % 3 == 0) ? 90 : ((blk % 3 == 1) ? 50 : 25);
      for (int c = 0; c < 400; c++) begin
        rst = ($urandom_range(0, 149) == 0);
        for (int k = 0; k < NREQ; k++) begin
          if (!(valid[k] && !last_ready[k])) begin
            set_req(k, ($urandom_range(0, 99) < pv),
                    ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7)),
                    $urandom);
          end
        end
        tick();
      end
    end
    rst = 1'b0;
    clear_reqs();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
